// File: rtl/btn_pkg.sv
// Shared definitions for the button press classifier: state encoding,
// default timing parameters and the parameter range check.
package btn_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        PRESS = ST_PRESS,
        HOLD  = ST_HOLD
    } btn_state_t;

    localparam int DEF_DIV_MS    = 100_000;
    localparam int DEF_LONG_MS   = 1000;
    localparam int DEF_REPEAT_MS = 200;

    function automatic bit params_ok(input int div_ms, input int long_ms, input int rep_ms);
        return (div_ms >= 2) && (long_ms >= 1) && (rep_ms >= 1);
    endfunction

    // Counter width for the larger threshold; at least one bit so a
    // threshold of 1 still yields a legal vector.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running clock divider producing a one-cycle tick every DIV clocks,
// with a synchronous clear to restart the period.
module ms_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int DW = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    assign o_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (i_clr || o_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/btn_press_fsm.sv
// Classifies a debounced button level into short/long/repeat pulses and a
// held flag. All outputs are registered from the next-state logic.
module btn_press_fsm
    import btn_pkg::*;
#(
    parameter int DIV_MS    = DEF_DIV_MS,
    parameter int LONG_MS   = DEF_LONG_MS,
    parameter int REPEAT_MS = DEF_REPEAT_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn,
    output logic       o_short,
    output logic       o_long,
    output logic       o_rep,
    output logic       o_held,
    output btn_state_t dbg_state
);

    generate
        if (!params_ok(DIV_MS, LONG_MS, REPEAT_MS)) begin : g_bad_params
            $error("btn_press_fsm: DIV_MS must be >= 2, LONG_MS and REPEAT_MS >= 1");
        end
    endgenerate

    localparam int MW = cnt_width(LONG_MS, REPEAT_MS);
    localparam logic [MW-1:0] LONG_LAST = MW'(LONG_MS - 1);
    localparam logic [MW-1:0] REP_LAST  = MW'(REPEAT_MS - 1);

    btn_state_t    state, state_d;
    logic [MW-1:0] ms_cnt, ms_d;
    logic          clr, tick;
    logic          short_d, long_d, rep_d;

    ms_tick_gen #(.DIV(DIV_MS)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (clr),
        .o_tick (tick)
    );

    // Release is tested first so it wins over a coincident threshold tick.
    always_comb begin
        state_d = state;
        ms_d    = ms_cnt;
        clr     = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state)
            IDLE: begin
                if (i_btn) begin
                    state_d = PRESS;
                    clr     = 1'b1;
                    ms_d    = '0;
                end
            end
            PRESS: begin
                if (!i_btn) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else if (tick && (ms_cnt == LONG_LAST)) begin
                    long_d  = 1'b1;
                    state_d = HOLD;
                    clr     = 1'b1;
                    ms_d    = '0;
                end else if (tick) begin
                    ms_d = ms_cnt + MW'(1);
                end
            end
            HOLD: begin
                if (!i_btn) begin
                    state_d = IDLE;
                end else if (tick && (ms_cnt == REP_LAST)) begin
                    rep_d = 1'b1;
                    ms_d  = '0;
                end else if (tick) begin
                    ms_d = ms_cnt + MW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ms_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ms_cnt  <= '0;
            o_short <= 1'b0;
            o_long  <= 1'b0;
            o_rep   <= 1'b0;
            o_held  <= 1'b0;
        end else begin
            state   <= state_d;
            ms_cnt  <= ms_d;
            o_short <= short_d;
            o_long  <= long_d;
            o_rep   <= rep_d;
            o_held  <= (state_d == HOLD);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_btn_press_fsm.sv
// Self-checking bench for btn_press_fsm: vector table for short presses,
// timestamp model for long/repeat/collision/reset and a random stream.
module tb_btn_press_fsm;
    import btn_pkg::*;

    localparam int DIV      = 4;
    localparam int LMS      = 5;
    localparam int RMS      = 3;
    localparam int LONG_CLK = DIV * LMS;
    localparam int REP_CLK  = DIV * RMS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_btn = 1'b0;
    logic       o_short, o_long, o_rep, o_held;
    btn_state_t dbg_state;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Expected {short,long,rep,held} and, for model-driven cycles, the state.
    logic [3:0] exp_q[$];
    logic [1:0] st_q[$];

    // Timestamp model: mode 0 idle, 1 pressed, 2 held; e0 = edge entering PRESS.
    int m_mode = 0;
    int m_e0   = 0;

    typedef struct {
        logic       btn;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs[$];

    btn_press_fsm #(.DIV_MS(DIV), .LONG_MS(LMS), .REPEAT_MS(RMS)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_btn     (i_btn),
        .o_short   (o_short),
        .o_long    (o_long),
        .o_rep     (o_rep),
        .o_held    (o_held),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: edge=%0d got=%b expected=%b", name, edge_n, got, exp);
        end
    endtask

    task automatic drive(input string name, input logic b, input logic [3:0] exp,
                         input bit chk_st, input logic [1:0] exp_st);
        logic [3:0] e;
        logic [1:0] s;
        i_btn = b;
        exp_q.push_back(exp);
        if (chk_st) st_q.push_back(exp_st);
        @(posedge clk);
        @(negedge clk);
        edge_n++;
        e = exp_q.pop_front();
        check(name, {o_short, o_long, o_rep, o_held}, e);
        if (chk_st) begin
            s = st_q.pop_front();
            check({name, "_state"}, {2'b00, dbg_state}, {2'b00, s});
        end
        check("exclusive", {3'b000, (32'($countones({o_short, o_long, o_rep})) > 1)}, 4'h0);
        check("held_vs_state", {3'b000, o_held}, {3'b000, dbg_state == HOLD});
    endtask

    task automatic model_step(input logic b, output logic [3:0] o, output logic [1:0] st);
        int n;
        n = edge_n + 1;
        o = 4'b0000;
        case (m_mode)
            0: if (b) begin m_mode = 1; m_e0 = n; end
            1: begin
                if (!b) begin
                    o = 4'b1000;
                    m_mode = 0;
                end else if (n - m_e0 == LONG_CLK) begin
                    o = 4'b0101;
                    m_mode = 2;
                end
            end
            default: begin
                if (!b) m_mode = 0;
                else if ((n - m_e0 - LONG_CLK) % REP_CLK == 0) o = 4'b0011;
                else o = 4'b0001;
            end
        endcase
        st = 2'(m_mode);
    endtask

    task automatic run_model(input string name, input logic b);
        logic [3:0] o;
        logic [1:0] st;
        model_step(b, o, st);
        drive(name, b, o, 1'b1, st);
    endtask

    task automatic add_vec(input logic b, input logic [3:0] e, input int n);
        vec_t v;
        v.btn = b;
        v.exp = e;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        // Short press, then two back-to-back 6-cycle presses with 1 low cycle.
        add_vec(1'b0, 4'b0000, 2);
        add_vec(1'b1, 4'b0000, 10);
        add_vec(1'b0, 4'b1000, 1);
        add_vec(1'b0, 4'b0000, 3);
        add_vec(1'b1, 4'b0000, 6);
        add_vec(1'b0, 4'b1000, 1);
        add_vec(1'b1, 4'b0000, 6);
        add_vec(1'b0, 4'b1000, 1);
        add_vec(1'b0, 4'b0000, 3);

        #1;
        check("reset_outputs", {o_short, o_long, o_rep, o_held}, 4'b0000);
        check("reset_state", {2'b00, dbg_state}, {2'b00, ST_IDLE});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive("table", vecs[i].btn, vecs[i].exp, 1'b0, 2'b00);
        end

        // Long press with repeats: 50 cycles held.
        for (int i = 0; i < 50; i++) run_model("long_hold", 1'b1);
        for (int i = 0; i < 3; i++) run_model("long_release", 1'b0);

        // Release sampled exactly on the long-threshold edge.
        for (int i = 0; i < LONG_CLK; i++) run_model("collision", 1'b1);
        run_model("collision_rel", 1'b0);
        for (int i = 0; i < 2; i++) run_model("collision_idle", 1'b0);

        // Reset asserted mid-hold while the button stays pressed.
        for (int i = 0; i < 36; i++) run_model("pre_reset", 1'b1);
        rst = 1'b0;
        #1;
        check("async_reset_out", {o_short, o_long, o_rep, o_held}, 4'b0000);
        check("async_reset_state", {2'b00, dbg_state}, {2'b00, ST_IDLE});
        m_mode = 0;
        for (int i = 0; i < 3; i++) drive("in_reset", 1'b1, 4'b0000, 1'b1, ST_IDLE);
        rst = 1'b1;
        for (int i = 0; i < 50; i++) run_model("post_reset", 1'b1);
        for (int i = 0; i < 3; i++) run_model("post_reset_rel", 1'b0);

        // Random level stream with mixed run lengths.
        begin
            int total;
            int len;
            logic b;
            total = 0;
            b = 1'b0;
            while (total < 10000) begin
                b = ~b;
                len = (b && ($urandom_range(0, 3) == 0)) ? $urandom_range(20, 60)
                                                          : $urandom_range(1, 25);
                for (int i = 0; i < len; i++) run_model("random", b);
                total += len;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
